sensor_trace_buffer: RTL and testbench
======================================

// Module: sensor_trace_buffer
// PURPOSE
//  Captures one on-chip sensor trace per encryption. Takes the decoded TDC byte each
//  cycle and stores SAMPLES bytes, starting at the AES start strobe. Marks the cycle
//  where the ciphertext becomes valid. Streams the stored trace byte-by-byte to the
//  UART transmit sequencer through a valid/ready handshake.
//  Sits between tdc_decode (upstream) and the main FSM / uart_tx path (downstream).
// PARAMETERS
//  SAMPLES     1024  trace length in bytes, including the start marker; power of 2, >=4
//  AW          10    address width, $clog2(SAMPLES)
//  DECIM       1     store every DECIM-th cycle during capture; 1..255
//  START_MARK  8'hFA byte written to address 0 at trigger
//  END_MARK    8'hFF byte stored instead of the sample while mark_in=1
// PORTS
//  clk          in   1   sensor clock (fast domain); all logic on posedge
//  rst          in   1   asynchronous, active-high reset
//  arm          in   1   pulse: IDLE->ARMED
//  trig         in   1   AES start strobe (Drdy); starts capture when ARMED
//  mark_in      in   1   AES done (Dvld); substitutes END_MARK for the current sample
//  sample_in    in   8   decoded TDC popcount from tdc_decode
//  abort        in   1   synchronous return to IDLE from any state
//  rd_start     in   1   pulse: FULL->READOUT
//  tx_ready     in   1   consumer accepts tx_data this cycle
//  tx_valid     out  1   tx_data is valid; held until accepted
//  tx_data      out  8   trace byte, address order 0..SAMPLES-1
//  busy         out  1   1 in ARMED, CAPTURE, READOUT
//  full         out  1   1 in FULL (trace complete, not yet read)
//  rd_done      out  1   1-cycle pulse after the last byte is accepted
//  missed_trig  out  8   saturating count of trig pulses seen outside ARMED; cleared by arm
// BEHAVIOUR
//  Reset: state=IDLE; tx_valid=0, tx_data=0, busy=0, full=0, rd_done=0, missed_trig=0.
//   Address and decimation counters are 0. RAM contents are not reset.
//  IDLE: arm=1 -> ARMED, missed_trig<=0. trig ignored (counted).
//  ARMED: trig=1 -> write START_MARK to addr 0, wr_addr<=1, dec_cnt<=0 -> CAPTURE.
//  CAPTURE: dec_cnt counts 0..DECIM-1.
//   When dec_cnt==DECIM-1 (every cycle if DECIM=1): mem[wr_addr]<=mark_in?END_MARK:sample_in.
//   First stored sample is the value on the cycle after trig.
//   Last write at wr_addr==SAMPLES-1 -> FULL next cycle. wr_addr never wraps.
//  FULL: holds the trace indefinitely. rd_start=1 -> READOUT with rd_addr=0.
//  READOUT uses two substates, so throughput is at most 1 byte per 2 cycles:
//   - RD_FETCH: present rd_addr to the RAM.
//   - RD_SEND: tx_valid=1, tx_data=RAM q (registered). Holds until tx_ready=1.
//   - On accept: rd_addr==SAMPLES-1 -> IDLE and pulse rd_done. Otherwise rd_addr+1 -> RD_FETCH.
//   - tx_data and tx_valid must stay stable while tx_valid=1 and tx_ready=0.
//  Priority/simultaneity:
//   - abort > every other input; abort drops tx_valid the next cycle, no rd_done.
//   - arm and trig together in IDLE: arm only, no capture.
//   - trig in CAPTURE/FULL/READOUT: missed_trig+1, saturating at 255.
//   - rd_start outside FULL ignored; arm outside IDLE ignored.
//  Reset mid-capture or mid-readout: immediate IDLE, outputs as at reset; the partial trace is lost.
// STRUCTURE
//  Shared package sensor_pkg: state encoding (IDLE, ARMED, CAPTURE, FULL, RD_FETCH, RD_SEND)
//   and the START_MARK/END_MARK defaults.
//  Sub-module trace_ram: simple dual-port, 1 write port / 1 read port, registered read,
//   SAMPLES x 8, inferred block RAM, no reset.
// TESTING
//  T1 SAMPLES=16, DECIM=1; arm, trig, sample_in=cycle index, consumer tx_ready=1
//   -> bytes FA,1,2..15; full before rd_start; rd_done once.
//  T2 mark_in=1 on 5th post-trig cycle -> byte[5]=FF; all other bytes are samples.
//  T3 DECIM=3, sample_in=cycle index -> stored bytes = index 3,6,9..; FULL after 45 cycles.
//  T4 tx_ready random 30% -> no byte lost or duplicated; tx_data stable while stalled.
//  T5 trig x3 while FULL, then arm after readout -> missed_trig=3, then 0;
//   300 trig pulses outside ARMED -> missed_trig=255.
//  T6 rst mid-CAPTURE and abort mid-READOUT -> IDLE next edge, tx_valid=0, no rd_done;
//   next full cycle passes T1.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor trace buffer: controller state encoding and
// the default marker bytes framing a captured trace.
package sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_FULL     = 3'd3,
        ST_RD_FETCH = 3'd4,
        ST_RD_SEND  = 3'd5
    } state_t;

    localparam logic [7:0] START_MARK_DEF = 8'hFA;
    localparam logic [7:0] END_MARK_DEF   = 8'hFF;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one registered read port with
// read enable so the read data holds while the consumer stalls. No reset.
module trace_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    q
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            q <= mem[raddr];
    end

endmodule

// File: rtl/sensor_trace_buffer.sv
// Captures one sensor trace per encryption into trace_ram and streams it out
// over a valid/ready byte interface.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | waiting for arm
//   ST_ARMED    | waiting for trig; writes START_MARK to addr 0 on trig
//   ST_CAPTURE  | storing every DECIM-th sample until the last address
//   ST_FULL     | trace complete, waiting for rd_start
//   ST_RD_FETCH | RAM read of rd_addr in flight
//   ST_RD_SEND  | byte presented with tx_valid until tx_ready
module sensor_trace_buffer
    import sensor_pkg::*;
#(
    parameter int         SAMPLES    = 1024,
    parameter int         AW         = $clog2(SAMPLES),
    parameter int         DECIM      = 1,
    parameter logic [7:0] START_MARK = START_MARK_DEF,
    parameter logic [7:0] END_MARK   = END_MARK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       trig,
    input  logic       mark_in,
    input  logic [7:0] sample_in,
    input  logic       abort,
    input  logic       rd_start,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       full,
    output logic       rd_done,
    output logic [7:0] missed_trig
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPLES - 1);
    localparam logic [7:0]    DEC_LAST  = 8'(DECIM - 1);

    state_t        state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    dec_cnt;
    logic          dec_hit;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic          ram_re;
    logic [7:0]    ram_q;

    assign dec_hit = (dec_cnt == DEC_LAST);
    assign ram_re  = (state == ST_RD_FETCH);
    // RAM q is unreset, so the output is masked to keep tx_data clean when idle
    assign tx_data = tx_valid ? ram_q : 8'h00;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = 8'h00;
        if (!abort) begin
            if (state == ST_ARMED && trig) begin
                ram_we    = 1'b1;
                ram_wdata = START_MARK;
            end else if (state == ST_CAPTURE && dec_hit) begin
                ram_we    = 1'b1;
                ram_waddr = wr_addr;
                ram_wdata = mark_in ? END_MARK : sample_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            dec_cnt     <= 8'd0;
            missed_trig <= 8'd0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            full        <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
                full     <= 1'b0;
            end else begin
                // arm in IDLE clears the count below, overriding this increment
                if (trig && state != ST_ARMED && missed_trig != 8'hFF)
                    missed_trig <= missed_trig + 8'd1;
                case (state)
                    ST_IDLE: begin
                        if (arm) begin
                            state       <= ST_ARMED;
                            missed_trig <= 8'd0;
                            busy        <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            state   <= ST_CAPTURE;
                            wr_addr <= AW'(1);
                            dec_cnt <= 8'd0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (dec_hit) begin
                            dec_cnt <= 8'd0;
                            if (wr_addr == LAST_ADDR) begin
                                state <= ST_FULL;
                                busy  <= 1'b0;
                                full  <= 1'b1;
                            end else begin
                                wr_addr <= wr_addr + 1'b1;
                            end
                        end else begin
                            dec_cnt <= dec_cnt + 8'd1;
                        end
                    end
                    ST_FULL: begin
                        if (rd_start) begin
                            state   <= ST_RD_FETCH;
                            rd_addr <= '0;
                            busy    <= 1'b1;
                            full    <= 1'b0;
                        end
                    end
                    ST_RD_FETCH: begin
                        state    <= ST_RD_SEND;
                        tx_valid <= 1'b1;
                    end
                    ST_RD_SEND: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            if (rd_addr == LAST_ADDR) begin
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                                rd_done <= 1'b1;
                            end else begin
                                rd_addr <= rd_addr + 1'b1;
                                state   <= ST_RD_FETCH;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    trace_ram #(
        .DEPTH (SAMPLES),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_addr),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_sensor_trace_buffer.sv
// Directed bench for sensor_trace_buffer: two 16-sample instances (DECIM=1 and
// DECIM=3) share stimulus; a control vector table plus capture/readout sequences.
module tb_sensor_trace_buffer;

    logic       clk = 1'b0;
    logic       rst, arm, trig, mark_in, abort, rd_start, tx_ready;
    logic [7:0] sample_in;

    logic       tx_valid1, busy1, full1, rd_done1;
    logic [7:0] tx_data1, missed1;
    logic       tx_valid3, busy3, full3, rd_done3;
    logic [7:0] tx_data3, missed3;

    logic       sel3;
    logic       tv, bs, fl, rdd;
    logic [7:0] td, ms;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_mem [16];

    always #5 clk = ~clk;

    sensor_trace_buffer #(.SAMPLES(16), .DECIM(1)) u_dut1 (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .mark_in(mark_in),
        .sample_in(sample_in), .abort(abort), .rd_start(rd_start), .tx_ready(tx_ready),
        .tx_valid(tx_valid1), .tx_data(tx_data1), .busy(busy1), .full(full1),
        .rd_done(rd_done1), .missed_trig(missed1)
    );

    sensor_trace_buffer #(.SAMPLES(16), .DECIM(3)) u_dut3 (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .mark_in(mark_in),
        .sample_in(sample_in), .abort(abort), .rd_start(rd_start), .tx_ready(tx_ready),
        .tx_valid(tx_valid3), .tx_data(tx_data3), .busy(busy3), .full(full3),
        .rd_done(rd_done3), .missed_trig(missed3)
    );

    assign tv  = sel3 ? tx_valid3 : tx_valid1;
    assign td  = sel3 ? tx_data3  : tx_data1;
    assign bs  = sel3 ? busy3     : busy1;
    assign fl  = sel3 ? full3     : full1;
    assign rdd = sel3 ? rd_done3  : rd_done1;
    assign ms  = sel3 ? missed3   : missed1;

    typedef struct {
        logic       arm;
        logic       trig;
        logic       abort;
        logic       rd_start;
        logic       exp_busy;
        logic       exp_full;
        logic [7:0] exp_missed;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample_in = sample_in + 8'd1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // arm, trig with sample_in=0, then run until full; mark_at<0 means no mark
    task automatic capture(input logic s3, input int mark_at, input int exp_cycles);
        int n;
        sel3 = s3;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_busy", bs, 1'b1);
        trig = 1'b1;
        sample_in = 8'd0;
        tick();
        trig = 1'b0;
        n = 0;
        mark_in = (int'(sample_in) == mark_at);
        while (!fl && n < 200) begin
            tick();
            n++;
            mark_in = (int'(sample_in) == mark_at);
        end
        mark_in = 1'b0;
        chk("capture_cycles", n, exp_cycles);
        chk("full_busy", bs, 1'b0);
    endtask

    task automatic readout(input int ready_pct);
        int   idx, n, dones;
        logic prev_stall;
        logic [7:0] prev_data;
        chk("full_before_rd", fl, 1'b1);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("rd_full_clear", fl, 1'b0);
        idx = 0; n = 0; dones = 0; prev_stall = 1'b0; prev_data = 8'h00;
        while (idx < 16 && n < 600) begin
            if (prev_stall) begin
                chk("stall_valid", tv, 1'b1);
                chk("stall_data", td, prev_data);
            end
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (tv && tx_ready) begin
                chk($sformatf("byte%0d", idx), td, exp_mem[idx]);
                idx++;
            end
            prev_stall = tv && !tx_ready;
            prev_data  = td;
            tick();
            n++;
            if (rdd) dones++;
        end
        tx_ready = 1'b0;
        chk("bytes_read", idx, 16);
        repeat (3) begin
            tick();
            if (rdd) dones++;
        end
        chk("rd_done_count", dones, 1);
        chk("post_rd_busy", bs, 1'b0);
        chk("post_rd_valid", tv, 1'b0);
    endtask

    initial begin
        int n, dones;
        rst = 1'b1; arm = 1'b0; trig = 1'b0; mark_in = 1'b0; abort = 1'b0;
        rd_start = 1'b0; tx_ready = 1'b0; sample_in = 8'd0; sel3 = 1'b0;

        //            arm  trig abort rd   busy full missed
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy1, 1'b0);
        chk("rst_full", full1, 1'b0);
        chk("rst_valid", tx_valid1, 1'b0);
        chk("rst_data", tx_data1, 8'h00);
        chk("rst_rd_done", rd_done1, 1'b0);
        chk("rst_missed", missed1, 8'h00);
        chk("rst_busy3", busy3, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            arm = vecs[i].arm; trig = vecs[i].trig;
            abort = vecs[i].abort; rd_start = vecs[i].rd_start;
            tick();
            chk($sformatf("vec%0d_busy", i), busy1, vecs[i].exp_busy);
            chk($sformatf("vec%0d_full", i), full1, vecs[i].exp_full);
            chk($sformatf("vec%0d_missed", i), missed1, vecs[i].exp_missed);
            chk($sformatf("vec%0d_valid", i), tx_valid1, 1'b0);
        end
        arm = 1'b0; trig = 1'b0; abort = 1'b0; rd_start = 1'b0;

        // T1 + T5: plain trace, extra trigs while full, arm clears the count
        exp_mem[0] = 8'hFA;
        for (int i = 1; i < 16; i++) exp_mem[i] = 8'(i);
        capture(1'b0, -1, 15);
        repeat (3) begin
            trig = 1'b1; tick(); trig = 1'b0; tick();
        end
        chk("missed_full", missed1, 8'd3);
        chk("still_full", full1, 1'b1);
        readout(100);
        chk("missed_after_rd", missed1, 8'd3);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("missed_cleared", missed1, 8'd0);
        do_abort();

        // T2: end marker on the 5th post-trig sample
        exp_mem[5] = 8'hFF;
        capture(1'b0, 5, 15);
        readout(100);
        do_abort();

        // T3 + T4: decimation by 3, stalling consumer
        exp_mem[0] = 8'hFA;
        for (int i = 1; i < 16; i++) exp_mem[i] = 8'(3 * i);
        capture(1'b1, -1, 45);
        readout(30);
        do_abort();

        // T5: saturation of missed_trig
        sel3 = 1'b0;
        repeat (300) begin
            trig = 1'b1; tick(); trig = 1'b0;
        end
        chk("missed_sat1", missed1, 8'd255);
        chk("missed_sat3", missed3, 8'd255);

        // T6: async reset in the middle of a capture
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; sample_in = 8'd0; tick(); trig = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", busy1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy1, 1'b0);
        chk("async_rst_missed", missed1, 8'd0);
        chk("async_rst_valid", tx_valid1, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        chk("after_rst_busy", busy1, 1'b0);
        chk("after_rst_full", full1, 1'b0);

        // T6: abort while a byte is waiting in RD_SEND
        exp_mem[0] = 8'hFA;
        for (int i = 1; i < 16; i++) exp_mem[i] = 8'(i);
        capture(1'b0, -1, 15);
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        n = 0;
        while (!tx_valid1 && n < 10) begin tick(); n++; end
        chk("abort_pre_valid", tx_valid1, 1'b1);
        tx_ready = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_valid", tx_valid1, 1'b0);
        chk("abort_busy", busy1, 1'b0);
        dones = 0;
        repeat (4) begin
            if (rd_done1) dones++;
            tick();
        end
        chk("abort_no_rd_done", dones, 0);
        chk("abort_idle_valid", tx_valid1, 1'b0);

        // T6: next full cycle behaves like T1
        capture(1'b0, -1, 15);
        readout(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
